// File: rtl/regfile_ctx_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rms_pkg
// Description : Shared types and default constants for the register file with
//               hardware call-context stack: save/restore engine state
//               encoding and default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package rms_pkg;

    // Save/restore engine state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } ctxState_t;

    localparam int c_DATA_W      = 16;
    localparam int c_NREGS       = 64;
    localparam int c_SAVE_BASE   = 1;
    localparam int c_SAVE_CNT    = 15;
    localparam int c_STACK_DEPTH = 8;

endpackage : rms_pkg
`default_nettype wire

// File: rtl/regfile_ctx_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctx_stack_if
// Description : Port bundle of the register file: two read ports, two write
//               ports, the I/O register, save/restore requests and the
//               stack status / error flags.
//               master : the core side (drives enables, addresses, requests)
//               slave  : the register file itself
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_ctx_stack_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int DEPTH_W = 4
);
    logic              r1_en, r2_en;
    logic [ADDR_W-1:0] r1_addr, r2_addr;
    logic [DATA_W-1:0] r1_data, r2_data;
    logic              w1_en, w2_en;
    logic [ADDR_W-1:0] w1_addr, w2_addr;
    logic [DATA_W-1:0] w1_data, w2_data;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;
    logic              save, restore;
    logic              busy;
    logic [DEPTH_W-1:0] depth;
    logic              full, empty;
    logic              err_overflow, err_underflow;

    modport master (
        output r1_en, r2_en, r1_addr, r2_addr,
        output w1_en, w2_en, w1_addr, w2_addr, w1_data, w2_data,
        output io_in, save, restore,
        input  r1_data, r2_data, io_out, busy, depth, full, empty,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  r1_en, r2_en, r1_addr, r2_addr,
        input  w1_en, w2_en, w1_addr, w2_addr, w1_data, w2_data,
        input  io_in, save, restore,
        output r1_data, r2_data, io_out, busy, depth, full, empty,
        output err_overflow, err_underflow
    );
endinterface : regfile_ctx_stack_if
`default_nettype wire

// File: rtl/regfile_ctx_stack_ram.sv
`default_nettype none
// ============================================================================
// Module      : ctx_stack_ram
// Description : Context stack storage. Single port, synchronous write,
//               asynchronous read. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
// Revision    : 1.0 - initial release
// ============================================================================
module ctx_stack_ram #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 120,
    parameter int ADDR_W = 7
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];
endmodule : ctx_stack_ram
`default_nettype wire

// File: rtl/regfile_ctx_stack.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctx_stack
// Description : Register file with two registered read ports, two write ports,
//               a memory-mapped I/O register and a call-context stack. The
//               save/restore engine moves one window register per cycle
//               between the register array and ctx_stack_ram.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : port bundle (regfile_ctx_stack_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_ctx_stack
    import rms_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int NREGS       = c_NREGS,
    parameter int SAVE_BASE   = c_SAVE_BASE,
    parameter int SAVE_CNT    = c_SAVE_CNT,
    parameter int STACK_DEPTH = c_STACK_DEPTH,
    parameter int IO_ADDR     = NREGS - 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    regfile_ctx_stack_if.slave bus
);
    localparam int ADDR_W     = $clog2(NREGS);
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W      = (SAVE_CNT > 1) ? $clog2(SAVE_CNT) : 1;
    localparam int RAM_WORDS  = STACK_DEPTH * SAVE_CNT;
    localparam int RAM_ADDR_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    localparam logic [ADDR_W-1:0] c_IO  = ADDR_W'(IO_ADDR);
    localparam logic [IDX_W-1:0]  c_LAST = IDX_W'(SAVE_CNT - 1);

    ctxState_t           r_state, w_nextState;
    logic [IDX_W-1:0]    r_idx, w_nextIdx;
    logic [DEPTH_W-1:0]  r_depth, w_nextDepth;
    logic                r_ovf, w_nextOvf;
    logic                r_udf, w_nextUdf;

    logic [DATA_W-1:0]   r_regs [NREGS];
    logic [DATA_W-1:0]   r_ioOut, r_r1Data, r_r2Data;
    logic [DATA_W-1:0]   w_r1Next, w_r2Next;

    logic                w_busy, w_full, w_empty;
    logic [DEPTH_W-1:0]  w_frame;
    logic [RAM_ADDR_W-1:0] w_ramAddr;
    logic [ADDR_W-1:0]   w_winAddr;
    logic [DATA_W-1:0]   w_ramRdata;

    assign w_busy  = (r_state != IDLE);
    assign w_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty = (r_depth == '0);

    // Save writes the frame at depth; restore reads the frame just below it.
    always_comb begin
        w_frame   = (r_state == RESTORE) ? (r_depth - 1'b1) : r_depth;
        w_ramAddr = RAM_ADDR_W'(32'(w_frame) * SAVE_CNT + 32'(r_idx));
        w_winAddr = ADDR_W'(SAVE_BASE + 32'(r_idx));
    end

    ctx_stack_ram #(
        .DATA_W (DATA_W),
        .WORDS  (RAM_WORDS),
        .ADDR_W (RAM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (r_state == SAVE),
        .addr  (w_ramAddr),
        .wdata (r_regs[w_winAddr]),
        .rdata (w_ramRdata)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
            r_depth <= w_nextDepth;
            r_ovf   <= w_nextOvf;
            r_udf   <= w_nextUdf;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextDepth = r_depth;
        w_nextOvf   = r_ovf;
        w_nextUdf   = r_udf;
        case (r_state)
            IDLE: begin
                if (bus.save) begin
                    if (!w_full) begin
                        w_nextState = SAVE;
                        w_nextIdx   = '0;
                    end else begin
                        w_nextOvf = 1'b1;
                    end
                end else if (bus.restore) begin
                    if (!w_empty) begin
                        w_nextState = RESTORE;
                        w_nextIdx   = '0;
                    end else begin
                        w_nextUdf = 1'b1;
                    end
                end
            end
            SAVE, RESTORE: begin
                if (r_idx == c_LAST) begin
                    w_nextState = IDLE;
                    w_nextIdx   = '0;
                    w_nextDepth = (r_state == SAVE) ? (r_depth + 1'b1) : (r_depth - 1'b1);
                end else begin
                    w_nextIdx = r_idx + 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // ---------------- read ports ----------------
    // Write-first bypass; w2 is checked first because it wins over w1.
    function automatic logic [DATA_W-1:0] readMux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              w1En,
        input logic [ADDR_W-1:0] w1Addr,
        input logic [DATA_W-1:0] w1Data,
        input logic              w2En,
        input logic [ADDR_W-1:0] w2Addr,
        input logic [DATA_W-1:0] w2Data,
        input logic [DATA_W-1:0] ioIn
    );
        if (addr == '0)                    return '0;
        else if (addr == c_IO)             return ioIn;
        else if (w2En && (w2Addr == addr)) return w2Data;
        else if (w1En && (w1Addr == addr)) return w1Data;
        else                               return stored;
    endfunction

    always_comb begin
        w_r1Next = readMux(bus.r1_addr, r_regs[bus.r1_addr], bus.w1_en, bus.w1_addr,
                           bus.w1_data, bus.w2_en, bus.w2_addr, bus.w2_data, bus.io_in);
        w_r2Next = readMux(bus.r2_addr, r_regs[bus.r2_addr], bus.w1_en, bus.w1_addr,
                           bus.w1_data, bus.w2_en, bus.w2_addr, bus.w2_data, bus.io_in);
    end

    // ---------------- register array, I/O register, read data ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_ioOut  <= '0;
            r_r1Data <= '0;
            r_r2Data <= '0;
        end else if (r_state == RESTORE) begin
            r_regs[w_winAddr] <= w_ramRdata;
        end else if (r_state == IDLE) begin
            // w2 assigned last so it wins on a shared address.
            if (bus.w1_en) begin
                if (bus.w1_addr == c_IO)       r_ioOut <= bus.w1_data;
                else if (bus.w1_addr != '0)    r_regs[bus.w1_addr] <= bus.w1_data;
            end
            if (bus.w2_en) begin
                if (bus.w2_addr == c_IO)       r_ioOut <= bus.w2_data;
                else if (bus.w2_addr != '0)    r_regs[bus.w2_addr] <= bus.w2_data;
            end
            if (bus.r1_en) r_r1Data <= w_r1Next;
            if (bus.r2_en) r_r2Data <= w_r2Next;
        end
    end

    assign bus.r1_data       = r_r1Data;
    assign bus.r2_data       = r_r2Data;
    assign bus.io_out        = r_ioOut;
    assign bus.busy          = w_busy;
    assign bus.depth         = r_depth;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.err_overflow  = r_ovf;
    assign bus.err_underflow = r_udf;
endmodule : regfile_ctx_stack
`default_nettype wire
